// File: rtl/gestor_tablero.sv
// gestor_tablero: Connect-4 board writer. Owns the FILAS x COLUMNAS board,
// applies gravity one row per cycle, writes the mover's piece, then samples
// the external win detector to decide between next turn, win and draw.
// Optional build macro TURNO_TIMEOUT_EN adds an idle-turn forfeit timer.
module gestor_tablero #(
    parameter int FILAS           = 6,
    parameter int COLUMNAS        = 7,
    parameter int JUGADOR_INICIAL = 1,
    parameter int TIEMPO_TURNO    = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nuevo_juego,
    input  logic       soltar,
    input  logic [2:0] columna,
    input  logic       hay_ganador,
    input  logic [1:0] jugador_ganador,
    output logic [1:0] tablero [0:FILAS-1][0:COLUMNAS-1],
    output logic [1:0] jugador_actual,
    output logic       listo,
    output logic       movimiento_ok,
    output logic       columna_llena,
    output logic       columna_invalida,
    output logic       fin_juego,
    output logic [1:0] ganador,
    output logic       empate,
    output logic       turno_perdido
);
    typedef enum logic [2:0] {ESPERA, BUSCAR, ESCRIBIR, EVALUAR, FIN} estado_t;

    localparam int            FW           = (FILAS > 1) ? $clog2(FILAS) : 1;
    localparam logic [FW-1:0] FILA_FONDO   = FW'(FILAS - 1);
    localparam logic [3:0]    NUM_COLS     = 4'(COLUMNAS);
    localparam logic [5:0]    TOTAL_FICHAS = 6'(FILAS * COLUMNAS);
    localparam logic [1:0]    JUG_INI      = 2'(JUGADOR_INICIAL);

    estado_t       state_q, state_d;
    logic [2:0]    col_q, col_d;
    // fila_q walks up from the bottom row and, once a free cell is found,
    // stays put as the target row for the write.
    logic [FW-1:0] fila_q, fila_d;
    logic [5:0]    fichas_q, fichas_d;
    logic [1:0]    jugador_q, jugador_d;
    logic          fin_q, fin_d;
    logic [1:0]    ganador_q, ganador_d;
    logic          empate_q, empate_d;
    logic          invalida_q, invalida_d;
    logic [1:0]    tablero_q [0:FILAS-1][0:COLUMNAS-1];
    logic [1:0]    tablero_d [0:FILAS-1][0:COLUMNAS-1];
    logic          celda_libre;
`ifdef TURNO_TIMEOUT_EN
    localparam int            TW     = $clog2(TIEMPO_TURNO + 1);
    localparam logic [TW-1:0] LIMITE = TW'(TIEMPO_TURNO - 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          perdido;
`endif

    function automatic logic [1:0] otro_jugador(input logic [1:0] j);
        return (j == 2'd1) ? 2'd2 : 2'd1;
    endfunction

    assign celda_libre = (tablero_q[fila_q][col_q] == 2'd0);

    // Move sequencer: next state, single-cell board update and status pulses.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        fila_d        = fila_q;
        fichas_d      = fichas_q;
        jugador_d     = jugador_q;
        fin_d         = fin_q;
        ganador_d     = ganador_q;
        empate_d      = empate_q;
        invalida_d    = 1'b0;
        tablero_d     = tablero_q;
        listo         = 1'b0;
        movimiento_ok = 1'b0;
        columna_llena = 1'b0;
`ifdef TURNO_TIMEOUT_EN
        timer_d       = '0;
        perdido       = 1'b0;
`endif
        case (state_q)
            ESPERA: begin
                listo = 1'b1;
                if (soltar) begin
                    if ({1'b0, columna} < NUM_COLS) begin
                        col_d   = columna;
                        fila_d  = FILA_FONDO;
                        state_d = BUSCAR;
                    end else begin
                        invalida_d = 1'b1;
                    end
                end
`ifdef TURNO_TIMEOUT_EN
                else if (timer_q == LIMITE) begin
                    perdido   = 1'b1;
                    jugador_d = otro_jugador(jugador_q);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end
            BUSCAR: begin
                if (celda_libre) begin
                    state_d = ESCRIBIR;
                end else if (fila_q == '0) begin
                    columna_llena = 1'b1;
                    state_d       = ESPERA;
                end else begin
                    fila_d = fila_q - FW'(1);
                end
            end
            ESCRIBIR: begin
                tablero_d[fila_q][col_q] = jugador_q;
                fichas_d                 = fichas_q + 6'd1;
                state_d                  = EVALUAR;
            end
            EVALUAR: begin
                // The detector has had one full cycle to see the new piece.
                if (hay_ganador) begin
                    ganador_d = jugador_ganador;
                    fin_d     = 1'b1;
                    state_d   = FIN;
                end else if (fichas_q == TOTAL_FICHAS) begin
                    empate_d = 1'b1;
                    fin_d    = 1'b1;
                    state_d  = FIN;
                end else begin
                    jugador_d     = otro_jugador(jugador_q);
                    movimiento_ok = 1'b1;
                    state_d       = ESPERA;
                end
            end
            FIN: begin
                state_d = FIN;
            end
            default: state_d = ESPERA;
        endcase

        // A new game overrides whatever the sequencer decided this cycle.
        if (nuevo_juego) begin
            state_d       = ESPERA;
            col_d         = '0;
            fila_d        = '0;
            fichas_d      = '0;
            jugador_d     = JUG_INI;
            fin_d         = 1'b0;
            ganador_d     = 2'd0;
            empate_d      = 1'b0;
            invalida_d    = 1'b0;
            movimiento_ok = 1'b0;
            columna_llena = 1'b0;
            for (int f = 0; f < FILAS; f++) begin
                for (int c = 0; c < COLUMNAS; c++) begin
                    tablero_d[f][c] = 2'd0;
                end
            end
`ifdef TURNO_TIMEOUT_EN
            timer_d = '0;
            perdido = 1'b0;
`endif
        end
    end

    // State, board and game-status registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ESPERA;
            col_q      <= '0;
            fila_q     <= '0;
            fichas_q   <= '0;
            jugador_q  <= JUG_INI;
            fin_q      <= 1'b0;
            ganador_q  <= 2'd0;
            empate_q   <= 1'b0;
            invalida_q <= 1'b0;
            for (int f = 0; f < FILAS; f++) begin
                for (int c = 0; c < COLUMNAS; c++) begin
                    tablero_q[f][c] <= 2'd0;
                end
            end
`ifdef TURNO_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            fila_q     <= fila_d;
            fichas_q   <= fichas_d;
            jugador_q  <= jugador_d;
            fin_q      <= fin_d;
            ganador_q  <= ganador_d;
            empate_q   <= empate_d;
            invalida_q <= invalida_d;
            tablero_q  <= tablero_d;
`ifdef TURNO_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign tablero          = tablero_q;
    assign jugador_actual   = jugador_q;
    assign fin_juego        = fin_q;
    assign ganador          = ganador_q;
    assign empate           = empate_q;
    assign columna_invalida = invalida_q;
`ifdef TURNO_TIMEOUT_EN
    assign turno_perdido    = perdido;
`else
    // No timer is built; the expression is constant 0 for any legal TIEMPO_TURNO.
    assign turno_perdido    = (TIEMPO_TURNO < 0);
`endif
endmodule

// File: tb/tb_gestor_tablero.sv
// tb_gestor_tablero: randomized scoreboard bench for gestor_tablero. A
// reference model (column heights + board array) predicts each move's
// outcome and timing; a monitor pops and compares on every DUT event.
`timescale 1ns/1ps
module tb_gestor_tablero;
    localparam int F = 6;
    localparam int C = 7;
    typedef logic [1:0] board_t [0:F-1][0:C-1];

    // kind: 0 move ok, 1 column full, 2 invalid column, 3 win, 4 draw
    typedef struct {
        int                 kind;
        int                 cyc;
        logic [1:0]         jug;
        logic [1:0]         gan;
        logic [2*F*C-1:0]   snap;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nuevo_juego = 1'b0;
    logic       soltar = 1'b0;
    logic [2:0] columna = 3'd0;
    logic       hay_ganador;
    logic [1:0] jugador_ganador;
    board_t     tablero;
    logic [1:0] jugador_actual;
    logic       listo, movimiento_ok, columna_llena, columna_invalida;
    logic       fin_juego, empate, turno_perdido;
    logic [1:0] ganador;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  stub = 1'b0;
    ev_t q[$];

    board_t     mb;
    int         alt [C];
    int         mfichas;
    logic [1:0] mjug;
    bit         mfin;

    gestor_tablero #(.FILAS(F), .COLUMNAS(C), .JUGADOR_INICIAL(1)) dut (
        .clk(clk), .rst_n(rst_n), .nuevo_juego(nuevo_juego), .soltar(soltar),
        .columna(columna), .hay_ganador(hay_ganador), .jugador_ganador(jugador_ganador),
        .tablero(tablero), .jugador_actual(jugador_actual), .listo(listo),
        .movimiento_ok(movimiento_ok), .columna_llena(columna_llena),
        .columna_invalida(columna_invalida), .fin_juego(fin_juego),
        .ganador(ganador), .empate(empate), .turno_perdido(turno_perdido)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Four in a row in any direction; returns the owning player or 0.
    function automatic logic [1:0] winner(input board_t b);
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < C; c++) begin
                if (b[r][c] != 2'd0) begin
                    for (int d = 0; d < 4; d++) begin
                        int dr, dc, n;
                        dr = (d == 0) ? 0 : 1;
                        dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
                        n = 1;
                        for (int k = 1; k < 4; k++) begin
                            int rr, cc;
                            rr = r + k * dr;
                            cc = c + k * dc;
                            if (rr >= 0 && rr < F && cc >= 0 && cc < C && b[rr][cc] == b[r][c]) n++;
                            else break;
                        end
                        if (n == 4) return b[r][c];
                    end
                end
            end
        end
        return 2'd0;
    endfunction

    function automatic logic [2*F*C-1:0] flat(input board_t b);
        logic [2*F*C-1:0] v;
        v = '0;
        for (int r = 0; r < F; r++)
            for (int c = 0; c < C; c++)
                v[(r*C+c)*2 +: 2] = b[r][c];
        return v;
    endfunction

    // Stand-in for detector_victoria, optionally forced to "no winner".
    always_comb begin
        jugador_ganador = 2'd0;
        if (!stub) jugador_ganador = winner(tablero);
        hay_ganador = (jugador_ganador != 2'd0);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void push(input int kind, input int c, input logic [1:0] j, input logic [1:0] g);
        ev_t e;
        e.kind = kind; e.cyc = c; e.jug = j; e.gan = g; e.snap = flat(mb);
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < F; r++)
            for (int c = 0; c < C; c++)
                mb[r][c] = 2'd0;
        for (int c = 0; c < C; c++) alt[c] = 0;
        mfichas = 0;
        mjug = 2'd1;
        mfin = 1'b0;
        q.delete();
    endfunction

    // Monitor: every DUT event must match the oldest predicted event.
    logic fin_prev = 1'b0;
    always @(negedge clk) begin : monitor
        int  kind;
        ev_t e;
        kind = -1;
        if (rst_n) begin
            if (movimiento_ok) kind = 0;
            else if (columna_llena) kind = 1;
            else if (columna_invalida) kind = 2;
            else if (fin_juego && !fin_prev) kind = empate ? 4 : 3;
            if (kind >= 0) begin
                if (q.size() == 0) begin
                    chk("evento_inesperado", kind, 128'd255);
                end else begin
                    e = q.pop_front();
                    chk("tipo_evento", kind, e.kind);
                    chk("ciclo_evento", cyc, e.cyc);
                    chk("tablero", flat(tablero), e.snap);
                    chk("jugador_actual", jugador_actual, e.jug);
                    if (kind >= 3) begin
                        chk("ganador", ganador, e.gan);
                        chk("listo_fin", listo, 0);
                    end
                end
            end
        end
        fin_prev <= fin_juego;
    end

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL evento_timeout: got none expected kind %0d", q[0].kind);
            q.delete();
        end
    endtask

    task automatic drop(input int col);
        int t, s, k;
        logic [1:0] w;
        t = 0;
        while (!listo && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!listo) begin
            checks++; errors++;
            $display("FAIL listo_timeout: got 0 expected 1");
            return;
        end
        s = cyc + 1;
        if (col >= C) begin
            push(2, s, mjug, 2'd0);
        end else if (alt[col] == F) begin
            push(1, s + F - 1, mjug, 2'd0);
        end else begin
            k = alt[col];
            mb[F-1-k][col] = mjug;
            alt[col]++;
            mfichas++;
            w = stub ? 2'd0 : winner(mb);
            if (w != 2'd0) begin
                push(3, s + k + 3, mjug, w);
                mfin = 1'b1;
            end else if (mfichas == F * C) begin
                push(4, s + k + 3, mjug, 2'd0);
                mfin = 1'b1;
            end else begin
                push(0, s + k + 2, mjug, 2'd0);
                mjug = (mjug == 2'd1) ? 2'd2 : 2'd1;
            end
        end
        soltar = 1'b1;
        columna = 3'(col);
        @(negedge clk);
        soltar = 1'b0;
        drain();
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_tablero"}, flat(tablero), 0);
        chk({nm, "_listo"}, listo, 1);
        chk({nm, "_jugador"}, jugador_actual, 1);
        chk({nm, "_fin"}, fin_juego, 0);
        chk({nm, "_ganador"}, ganador, 0);
        chk({nm, "_empate"}, empate, 0);
    endtask

    task automatic nuevo();
        nuevo_juego = 1'b1;
        @(negedge clk);
        nuevo_juego = 1'b0;
        model_reset();
        chk_idle("nuevo");
    endtask

    initial begin
        int col;
        model_reset();
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // First move into column 3, then turn hand-over.
        drop(3);
        @(negedge clk);
        chk("turno_tras_mov", jugador_actual, mjug);

        // Out-of-range column leaves everything alone.
        drop(7);
        chk("listo_invalida", listo, 1);

        // Fill column 0, then one more drop is rejected.
        nuevo();
        for (int i = 0; i < 7; i++) drop(0);

        // Vertical win for player 1; soltar in FIN is ignored.
        nuevo();
        for (int i = 0; i < 7; i++) drop((i % 2 == 0) ? 0 : 1);
        chk("fin_vertical", fin_juego, 1);
        soltar = 1'b1;
        columna = 3'd2;
        @(negedge clk);
        soltar = 1'b0;
        repeat (8) @(negedge clk);
        chk("fin_congelado_tablero", flat(tablero), flat(mb));
        chk("fin_congelado_listo", listo, 0);
        nuevo();

        // Random games, including invalid and full-column drops.
        for (int g = 0; g < 5; g++) begin
            for (int m = 0; m < 90 && !mfin; m++) drop($urandom_range(0, 7));
            nuevo();
        end

        // Draw: detector held at "no winner" while the board fills up.
        stub = 1'b1;
        nuevo();
        for (int m = 0; m < F * C; m++) begin
            do col = $urandom_range(0, C - 1); while (alt[col] == F);
            drop(col);
        end
        chk("empate", empate, 1);
        chk("empate_fin", fin_juego, 1);
        chk("empate_ganador", ganador, 0);
        stub = 1'b0;
        nuevo();

        // Asynchronous reset in the middle of the column search.
        for (int i = 0; i < 3; i++) drop(2);
        soltar = 1'b1;
        columna = 3'd2;
        @(negedge clk);
        soltar = 1'b0;
        @(negedge clk);
        chk("buscar_listo", listo, 0);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        chk_idle("reset_buscar");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("reset_buscar_tablero", flat(tablero), 0);
        chk("turno_perdido", turno_perdido, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gestor_tablero.md
Name: gestor_tablero

Overview:
- Sequential board writer for the Connect-4 game; owns the 6x7 board register array that detector_victoria reads.
- Accepts one column-drop request per turn, applies gravity by scanning the column from the bottom row, writes the current player's piece, then samples the detector's verdict.
- Alternates turns and flags column-full, out-of-range column, win and draw.
- Sits between the input/debounce logic and detector_victoria/VGA display.

Parameters:
- FILAS, 6, board rows; row 0 = top, row FILAS-1 = bottom.
- COLUMNAS, 7, board columns; column 0 = leftmost.
- JUGADOR_INICIAL, 1, player (1 or 2) who moves first after reset or nuevo_juego.
- TIEMPO_TURNO, 50_000_000, idle cycles before a turn is forfeited (used only with TURNO_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- nuevo_juego  in  1  synchronous clear, any state.
- soltar  in  1  drop request, sampled only while listo=1.
- columna  in  3  target column for soltar.
- hay_ganador  in  1  from detector_victoria, driven from tablero.
- jugador_ganador  in  2  from detector_victoria.
- tablero  out  [1:0] x [0:FILAS-1][0:COLUMNAS-1]  board; cell encoding 0 = empty, 1 = P1, 2 = P2; value 3 is never written.
- jugador_actual  out  2  player whose turn it is.
- listo  out  1  block accepts soltar.
- movimiento_ok  out  1  one-cycle pulse, piece placed and game continues.
- columna_llena  out  1  one-cycle pulse, drop rejected because the column is full.
- columna_invalida  out  1  one-cycle pulse, columna >= COLUMNAS.
- fin_juego  out  1  level, game over.
- ganador  out  2  0 = none or draw, else winning player; valid while fin_juego=1.
- empate  out  1  level, board full with no winner.
- turno_perdido  out  1  one-cycle pulse, timeout forfeit (0 without the macro).

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - all tablero cells 0; jugador_actual=JUGADOR_INICIAL; state ESPERA.
  - listo=1; all pulses 0; fin_juego=0; ganador=0; empate=0.
  - fichas counter (6 bit)=0; turn timer=0.
- nuevo_juego=1 clears to the reset values on the next edge, from any state. It has priority over soltar in the same cycle.
- FSM states: ESPERA, BUSCAR, ESCRIBIR, EVALUAR, FIN.
- ESPERA (listo=1):
  - soltar with columna < COLUMNAS: latch columna into col_r, set fila_r=FILAS-1, go to BUSCAR.
  - soltar with columna >= COLUMNAS: pulse columna_invalida, stay in ESPERA, turn unchanged.
- BUSCAR (listo=0), one row per cycle:
  - tablero[fila_r][col_r]==0: fila_obj=fila_r, go to ESCRIBIR.
  - cell occupied and fila_r==0: pulse columna_llena, return to ESPERA, board and turn unchanged.
  - cell occupied otherwise: fila_r decrements.
- ESCRIBIR: tablero[fila_obj][col_r] <= jugador_actual; fichas++; go to EVALUAR.
- EVALUAR: detector inputs have settled on the updated board; sample hay_ganador.
  - hay_ganador=1: ganador <= jugador_ganador, fin_juego <= 1, go to FIN.
  - else fichas == FILAS*COLUMNAS: empate <= 1, fin_juego <= 1, go to FIN.
  - else toggle jugador_actual (1<->2), pulse movimiento_ok, go to ESPERA.
- FIN: listo=0; board, ganador and empate are held; soltar is ignored; only nuevo_juego or rst_n exits.
- Latency from the soltar edge to the next listo=1, for a column holding k pieces (k<FILAS): k+4 cycles. Pulses are asserted in the final cycle before ESPERA.
- Full column: FILAS+1 cycles to the columna_llena pulse.
- Only one cell is written per move. Cells above fila_obj and in other columns never change during a move.
- rst_n asserted mid-move aborts the move with no partial write. nuevo_juego mid-move clears everything.

Optional Feature:
- Macro TURNO_TIMEOUT_EN.
- Defined:
  - a counter runs only in ESPERA and resets on any accepted or rejected soltar.
  - on reaching TIEMPO_TURNO-1, pulse turno_perdido, toggle jugador_actual, clear the counter, leave the board untouched.
  - the counter holds 0 outside ESPERA.
- Not defined: no counter is built; turno_perdido is tied 0; a player can wait indefinitely.

Test Plan:
- Reset, soltar col 3 -> after 4 cycles tablero[5][3]=1, movimiento_ok pulse, jugador_actual=2, all other cells 0.
- Six drops into col 0 alternating players, seventh drop -> cells [5..0][0]=1,2,1,2,1,2; columna_llena pulse 7 cycles after soltar; jugador_actual unchanged; board unchanged.
- soltar with columna=7 -> columna_invalida pulse next cycle, no state change, listo stays 1.
- P1 cols 0,0,0,0 interleaved with P2 cols 1,1,1 -> after the 4th P1 drop fin_juego=1, ganador=1, listo=0; a further soltar has no effect; nuevo_juego clears the board, jugador_actual=1.
- 42-move sequence with the detector stubbed to hay_ganador=0 -> empate=1, fin_juego=1, ganador=0 after the last write.
- With TURNO_TIMEOUT_EN and TIEMPO_TURNO=10, idle in ESPERA -> turno_perdido pulse at cycle 10, jugador_actual toggles, board unchanged; rst_n pulse mid-BUSCAR -> board all 0, listo=1.
